freq_gate_ctrl: RTL and testbench

- Gate-time sequencer for the frequency counter's BCD N-digit counter.
- Synchronises the measured input and converts its rising edges into single-cycle count enables, but only inside a fixed gate window.
- Clears the counter before each window, then latches the final digits plus an overflow flag for the OLED display path.
- Runs back-to-back measurements while run_in is high.

---
 rtl/freq_cnt_pkg.sv | 49 ++++
 rtl/freq_gate_ctrl_if.sv | 35 +++
 rtl/sync_edge_detect.sv | 41 ++++
 rtl/freq_gate_ctrl.sv | 162 ++++++++++++++++
 tb/tb_freq_gate_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/freq_cnt_pkg.sv
// -----------------------------------------------------------------------------
// freq_cnt_pkg
//   Shared types and constants for the frequency-counter gate sequencer.
//   - state_t       : gate sequencer states
//   - gate_range_t  : gate-window range selection (x1, /10, /100)
//   - GATE_DIV_*    : gate-length divisor table, indexed by range
//   - gate_len()    : window length in clocks for a base length and a range
//   - to_range()    : maps the raw 2-bit selector onto a range (3 acts as 2)
// -----------------------------------------------------------------------------
package freq_cnt_pkg;

  localparam int DIGITS_NUM_DEF = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    GATE   = 3'd2,
    SETTLE = 3'd3,
    LATCH  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    RANGE_X1   = 2'd0,
    RANGE_X10  = 2'd1,
    RANGE_X100 = 2'd2
  } gate_range_t;

  // Gate-length divisor table.
  localparam int unsigned GATE_DIV_X1   = 1;
  localparam int unsigned GATE_DIV_X10  = 10;
  localparam int unsigned GATE_DIV_X100 = 100;

  // A window never shrinks below one clock, even for short base lengths.
  function automatic int unsigned gate_len(input int unsigned base_cycles,
                                           input gate_range_t range);
    int unsigned len;
    case (range)
      RANGE_X10:  len = base_cycles / GATE_DIV_X10;
      RANGE_X100: len = base_cycles / GATE_DIV_X100;
      default:    len = base_cycles / GATE_DIV_X1;
    endcase
    return (len == 0) ? 1 : len;
  endfunction

  function automatic gate_range_t to_range(input logic [1:0] sel);
    return (sel == 2'd3) ? RANGE_X100 : gate_range_t'(sel);
  endfunction

endpackage

// File: rtl/freq_gate_ctrl_if.sv
// -----------------------------------------------------------------------------
// freq_gate_ctrl_if
//   Link between the gate sequencer and the BCD N-digit counter.
//   - cnt_reset_out  : counter clear (sequencer -> counter)
//   - cnt_enable_out : one-cycle count strobe (sequencer -> counter)
//   - cnt_digits_in  : counter BCD digits (counter -> sequencer)
//   - cnt_carry_in   : counter top-digit carry (counter -> sequencer)
//   Modports: master = sequencer side, slave = counter side.
// -----------------------------------------------------------------------------
interface freq_gate_ctrl_if
  import freq_cnt_pkg::*;
#(
  parameter int DIGITS_NUM = DIGITS_NUM_DEF
) ();

  logic                    cnt_reset_out;
  logic                    cnt_enable_out;
  logic [4*DIGITS_NUM-1:0] cnt_digits_in;
  logic                    cnt_carry_in;

  modport master (
    output cnt_reset_out,
    output cnt_enable_out,
    input  cnt_digits_in,
    input  cnt_carry_in
  );

  modport slave (
    input  cnt_reset_out,
    input  cnt_enable_out,
    output cnt_digits_in,
    output cnt_carry_in
  );

endinterface

// File: rtl/sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
//   Brings an asynchronous input into the clk_in domain and produces a
//   registered one-cycle pulse for each rising edge. Pulse appears
//   SYNC_STAGES+1 cycles after the input rises.
//   Ports:
//   - clk_in   : clock
//   - reset_in : synchronous active-high reset
//   - async_in : asynchronous input
//   - edge_out : one-cycle rising-edge pulse (registered)
// -----------------------------------------------------------------------------
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic async_in,
  output logic edge_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   edge_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, giving a true shift chain.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
      edge_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
    end
  end

  assign edge_out = edge_q;

endmodule

// File: rtl/freq_gate_ctrl.sv
// -----------------------------------------------------------------------------
// freq_gate_ctrl
//   Gate-time sequencer for the BCD N-digit counter. Each measurement clears
//   the counter, opens a gate window of GATE_CYCLES clocks during which rising
//   edges of signal_in become count strobes, waits one cycle for the last
//   increment to land, then latches the digits and a sticky overflow flag.
//   Runs back-to-back while run_in is high; period is window + 3 cycles.
//
//   Optional feature (macro FREQ_GATE_RANGE_EN): gate_sel_in selects a window
//   of GATE_CYCLES/1, /10 or /100 (sampled in CLEAR); dp_pos_out reports the
//   range of the latched result for decimal-point placement.
//
//   Ports:
//   - clk_in, reset_in      : clock, synchronous active-high reset
//   - run_in                : level, high = measure continuously
//   - signal_in             : asynchronous measured signal
//   - cnt_bus (master)      : counter clear/enable out, digits/carry in
//   - result_digits_out     : last latched BCD digits
//   - result_overflow_out   : latched count exceeded 10^DIGITS_NUM-1
//   - result_stb_out        : one-cycle pulse, aligned with new result_* values
//   - busy_out              : high in any state except IDLE
//   - gate_sel_in, dp_pos_out (FREQ_GATE_RANGE_EN only)
// -----------------------------------------------------------------------------
module freq_gate_ctrl
  import freq_cnt_pkg::*;
#(
  parameter int DIGITS_NUM  = DIGITS_NUM_DEF,
  parameter int GATE_CYCLES = 50_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    run_in,
  input  logic                    signal_in,
  freq_gate_ctrl_if.master        cnt_bus,
  output logic [4*DIGITS_NUM-1:0] result_digits_out,
  output logic                    result_overflow_out,
  output logic                    result_stb_out,
  output logic                    busy_out
`ifdef FREQ_GATE_RANGE_EN
  ,
  input  logic [1:0]              gate_sel_in,
  output logic [1:0]              dp_pos_out
`endif
);

  localparam int TIMER_W_RAW = $clog2(GATE_CYCLES + 1);
  localparam int TIMER_W     = (TIMER_W_RAW < 1) ? 1 : TIMER_W_RAW;

  // Timer load values are window length minus one: the timer counts down
  // to zero inclusive, so GATE lasts exactly the window length.
  localparam logic [TIMER_W-1:0] LOAD_X1 =
    TIMER_W'(gate_len(GATE_CYCLES, RANGE_X1) - 1);
`ifdef FREQ_GATE_RANGE_EN
  localparam logic [TIMER_W-1:0] LOAD_X10 =
    TIMER_W'(gate_len(GATE_CYCLES, RANGE_X10) - 1);
  localparam logic [TIMER_W-1:0] LOAD_X100 =
    TIMER_W'(gate_len(GATE_CYCLES, RANGE_X100) - 1);
`endif

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [TIMER_W-1:0]   load_val;
  logic                 sticky_ovf_q;
  logic                 stb_q;
  logic                 edge_pulse;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .async_in (signal_in),
    .edge_out (edge_pulse)
  );

`ifdef FREQ_GATE_RANGE_EN
  gate_range_t sel_range;
  gate_range_t range_q;

  assign sel_range = to_range(gate_sel_in);

  always_comb begin
    case (sel_range)
      RANGE_X10:  load_val = LOAD_X10;
      RANGE_X100: load_val = LOAD_X100;
      default:    load_val = LOAD_X1;
    endcase
  end
`else
  assign load_val = LOAD_X1;
`endif

  // NOTE: defaults are assigned before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE:   if (run_in) state_d = CLEAR;
      CLEAR: begin
        timer_d = load_val;
        state_d = GATE;
      end
      GATE: begin
        if (timer_q == '0) state_d = SETTLE;
        else               timer_d = timer_q - 1'b1;
      end
      SETTLE: state_d = LATCH;
      LATCH:  state_d = run_in ? CLEAR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the reset is synchronous and clears every flop here, including the
  // result registers, so downstream logic never sees stale data after reset.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q             <= IDLE;
      timer_q             <= '0;
      sticky_ovf_q        <= 1'b0;
      stb_q               <= 1'b0;
      result_digits_out   <= '0;
      result_overflow_out <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      stb_q   <= (state_q == LATCH);

      // Carry seen in SETTLE belongs to the final in-window increment.
      if (state_q == CLEAR)
        sticky_ovf_q <= 1'b0;
      else if ((state_q == GATE || state_q == SETTLE) && cnt_bus.cnt_carry_in)
        sticky_ovf_q <= 1'b1;

      if (state_q == LATCH) begin
        result_digits_out   <= cnt_bus.cnt_digits_in;
        result_overflow_out <= sticky_ovf_q;
      end
    end
  end

`ifdef FREQ_GATE_RANGE_EN
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      range_q    <= RANGE_X1;
      dp_pos_out <= 2'd0;
    end else begin
      if (state_q == CLEAR) range_q    <= sel_range;
      if (state_q == LATCH) dp_pos_out <= range_q;
    end
  end
`endif

  // Strobe is registered alongside the result so a consumer sampling on the
  // strobe sees the new digits in the same cycle.
  assign result_stb_out         = stb_q;
  assign busy_out               = (state_q != IDLE);
  assign cnt_bus.cnt_reset_out  = reset_in | (state_q == CLEAR);
  assign cnt_bus.cnt_enable_out = edge_pulse & (state_q == GATE);

endmodule

// File: tb/tb_freq_gate_ctrl.sv
module tb_freq_gate_ctrl;

  localparam int GATE_CYCLES = 100;
  localparam int SYNC_STAGES = 2;

  logic clk;
  logic reset_in;
  logic run_in;
  logic manual_sig;
  logic wave_sig;
  int   wave_half;
  logic signal_in;

  int unsigned cyc;
  int vectors;
  int miscompares;

  // 3-digit and 1-digit instances share all stimulus.
  freq_gate_ctrl_if #(.DIGITS_NUM(3)) bus3 ();
  freq_gate_ctrl_if #(.DIGITS_NUM(1)) bus1 ();

  logic [11:0] r3_digits;
  logic        r3_ovf, r3_stb, r3_busy;
  logic [3:0]  r1_digits;
  logic        r1_ovf, r1_stb, r1_busy;

`ifdef FREQ_GATE_RANGE_EN
  logic [1:0] gate_sel;
  logic [1:0] dp3, dp1;
`endif

  assign signal_in = wave_sig | manual_sig;

  freq_gate_ctrl #(
    .DIGITS_NUM (3), .GATE_CYCLES (GATE_CYCLES), .SYNC_STAGES (SYNC_STAGES)
  ) dut3 (
    .clk_in              (clk),
    .reset_in            (reset_in),
    .run_in              (run_in),
    .signal_in           (signal_in),
    .cnt_bus             (bus3),
    .result_digits_out   (r3_digits),
    .result_overflow_out (r3_ovf),
    .result_stb_out      (r3_stb),
    .busy_out            (r3_busy)
`ifdef FREQ_GATE_RANGE_EN
    ,
    .gate_sel_in         (gate_sel),
    .dp_pos_out          (dp3)
`endif
  );

  freq_gate_ctrl #(
    .DIGITS_NUM (1), .GATE_CYCLES (GATE_CYCLES), .SYNC_STAGES (SYNC_STAGES)
  ) dut1 (
    .clk_in              (clk),
    .reset_in            (reset_in),
    .run_in              (run_in),
    .signal_in           (signal_in),
    .cnt_bus             (bus1),
    .result_digits_out   (r1_digits),
    .result_overflow_out (r1_ovf),
    .result_stb_out      (r1_stb),
    .busy_out            (r1_busy)
`ifdef FREQ_GATE_RANGE_EN
    ,
    .gate_sel_in         (gate_sel),
    .dp_pos_out          (dp1)
`endif
  );

  // Behavioural BCD counters standing in for the team counter.
  logic [11:0] ctr3;
  logic [3:0]  ctr1;

  function automatic logic [11:0] bcd_inc3(input logic [11:0] v);
    logic [11:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus3.cnt_reset_out)       ctr3 <= 12'h000;
    else if (bus3.cnt_enable_out) ctr3 <= bcd_inc3(ctr3);
    if (bus1.cnt_reset_out)       ctr1 <= 4'h0;
    else if (bus1.cnt_enable_out) ctr1 <= (ctr1 == 4'd9) ? 4'd0 : ctr1 + 4'd1;
  end

  assign bus3.cnt_digits_in = ctr3;
  assign bus3.cnt_carry_in  = bus3.cnt_enable_out & (ctr3 == 12'h999);
  assign bus1.cnt_digits_in = ctr1;
  assign bus1.cnt_carry_in  = bus1.cnt_enable_out & (ctr1 == 4'h9);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Square-wave source: toggles every wave_half cycles, off when zero.
  initial begin
    int cnt;
    cnt      = 0;
    wave_sig = 1'b0;
    forever begin
      @(negedge clk);
      if (wave_half == 0) begin
        wave_sig = 1'b0;
        cnt      = 0;
      end else if (cnt + 1 >= wave_half) begin
        cnt      = 0;
        wave_sig = ~wave_sig;
      end else begin
        cnt = cnt + 1;
      end
    end
  end

  typedef struct packed {
    logic [11:0] d3;
    logic        o3;
    logic [3:0]  d1;
    logic        o1;
    logic [1:0]  dp;
  } exp_t;

  exp_t sb[$];
  int unsigned stb_cyc;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_exp(input logic [11:0] d3, input logic o3,
                                   input logic [3:0] d1, input logic o1,
                                   input logic [1:0] dp);
    exp_t e;
    e.d3 = d3; e.o3 = o3; e.d1 = d1; e.o1 = o1; e.dp = dp;
    sb.push_back(e);
  endfunction

  // Waits (bounded) for a result strobe and checks it against the oldest
  // scoreboard entry.
  task automatic wait_and_check(input string tag);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      if (r3_stb === 1'b1) seen = 1'b1;
    end
    check({tag, "_stb_seen"}, 32'(seen), 32'd1);
    stb_cyc = cyc;
    if (seen) begin
      check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({tag, "_stb1"},    32'(r1_stb),    32'd1);
        check({tag, "_digits3"}, 32'(r3_digits), 32'(e.d3));
        check({tag, "_ovf3"},    32'(r3_ovf),    32'(e.o3));
        check({tag, "_digits1"}, 32'(r1_digits), 32'(e.d1));
        check({tag, "_ovf1"},    32'(r1_ovf),    32'(e.o1));
`ifdef FREQ_GATE_RANGE_EN
        check({tag, "_dp3"},     32'(dp3),       32'(e.dp));
        check({tag, "_dp1"},     32'(dp1),       32'(e.dp));
`endif
      end
    end
  endtask

  initial begin
    int unsigned prev_cyc;
    int          quiet;

    vectors     = 0;
    miscompares = 0;
    reset_in    = 1'b1;
    run_in      = 1'b0;
    manual_sig  = 1'b0;
    wave_half   = 0;
`ifdef FREQ_GATE_RANGE_EN
    gate_sel    = 2'd0;
`endif

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy",      32'(r3_busy),             32'd0);
    check("rst_stb",       32'(r3_stb),              32'd0);
    check("rst_digits",    32'(r3_digits),           32'd0);
    check("rst_ovf",       32'(r3_ovf),              32'd0);
    check("rst_enable",    32'(bus3.cnt_enable_out), 32'd0);
    check("rst_cnt_reset", 32'(bus3.cnt_reset_out),  32'd1);
    check("rst_digits1",   32'(r1_digits),           32'd0);
    reset_in = 1'b0;
    @(negedge clk);
    check("idle_cnt_reset", 32'(bus3.cnt_reset_out), 32'd0);

    // Single rise whose strobe lands on the last GATE cycle: counted.
    push_exp(12'h001, 1'b0, 4'h1, 1'b0, 2'd0);
    run_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    run_in = 1'b0;
    repeat (97) @(posedge clk);
    @(negedge clk);
    manual_sig = 1'b1;
    wait_and_check("rise_last_gate");
    manual_sig = 1'b0;
    repeat (10) @(negedge clk);

    // Same rise one cycle later lands in SETTLE: not counted.
    push_exp(12'h000, 1'b0, 4'h0, 1'b0, 2'd0);
    run_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    run_in = 1'b0;
    repeat (98) @(posedge clk);
    @(negedge clk);
    manual_sig = 1'b1;
    wait_and_check("rise_settle");
    manual_sig = 1'b0;
    repeat (10) @(negedge clk);

    // Back-to-back with a period-4 wave: 25 strobes per 100-cycle window.
    wave_half = 2;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 4; i++) push_exp(12'h025, 1'b0, 4'h5, 1'b1, 2'd0);
    run_in = 1'b1;
    prev_cyc = 0;
    for (int i = 0; i < 3; i++) begin
      wait_and_check($sformatf("b2b%0d", i));
      if (i > 0) check($sformatf("b2b%0d_period", i), stb_cyc - prev_cyc, 32'd103);
      prev_cyc = stb_cyc;
      check($sformatf("b2b%0d_busy", i), 32'(r3_busy), 32'd1);
    end

    // Drop run_in ten cycles into GATE: one more full result, then idle.
    repeat (11) @(negedge clk);
    run_in = 1'b0;
    wait_and_check("run_drop");
    check("run_drop_period", stb_cyc - prev_cyc, 32'd103);
    check("run_drop_busy",   32'(r3_busy),        32'd0);
    quiet = 0;
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      if (bus3.cnt_reset_out || r3_stb || r3_busy) quiet++;
    end
    check("idle_quiet", 32'(quiet), 32'd0);

    // Reset mid-GATE for one cycle.
    run_in = 1'b1;
    repeat (50) @(negedge clk);
    check("mid_gate_busy", 32'(r3_busy), 32'd1);
    reset_in = 1'b1;
    run_in   = 1'b0;
    @(negedge clk);
    check("mrst_busy",      32'(r3_busy),             32'd0);
    check("mrst_stb",       32'(r3_stb),              32'd0);
    check("mrst_digits",    32'(r3_digits),           32'd0);
    check("mrst_ovf",       32'(r3_ovf),              32'd0);
    check("mrst_ovf1",      32'(r1_ovf),              32'd0);
    check("mrst_enable",    32'(bus3.cnt_enable_out), 32'd0);
    check("mrst_ctr3",      32'(ctr3),                32'd0);
    reset_in = 1'b0;
    quiet = 0;
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      if (r3_stb || r1_stb || r3_busy) quiet++;
    end
    check("mrst_no_stb", 32'(quiet), 32'd0);

`ifdef FREQ_GATE_RANGE_EN
    // Range /10: 10-cycle window, period-2 wave -> 5 strobes.
    gate_sel  = 2'd1;
    wave_half = 1;
    repeat (10) @(negedge clk);
    push_exp(12'h005, 1'b0, 4'h5, 1'b0, 2'd1);
    run_in = 1'b1;
    @(negedge clk);
    run_in = 1'b0;
    wait_and_check("range_x10");
    wave_half = 0;
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
